// File: rtl/v_hier_pkg.sv
// Shared types and helpers for the v_hier qvec datapath.
package v_hier_pkg;

  localparam int QVEC_W = 4;

  typedef logic [QVEC_W-1:0] qvec_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/v_hier_qvec_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module v_hier_qvec_mem
  import v_hier_pkg::*;
#(
  parameter int WIDTH = QVEC_W,
  parameter int DEPTH = 8,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] ent_vec [DEPTH];

  // Each entry is its own register so that no array is written from more than one process.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [WIDTH-1:0] ent_q;

    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(gi))) begin
        ent_q <= wdata;
      end
    end

    assign ent_vec[gi] = ent_q;
  end

  assign rdata = ent_vec[raddr];

endmodule

// File: rtl/v_hier_qvec_fifo.sv
// Synchronous FIFO buffering qvec samples with valid/ready output and a sticky overflow flag.
// Optional change-only capture is enabled by defining V_HIER_QVEC_FIFO_CHGONLY_EN.
module v_hier_qvec_fifo
  import v_hier_pkg::*;
#(
  parameter int WIDTH = QVEC_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] rdata;
  logic             full, pop, push, drop, offered, is_new;

`ifdef V_HIER_QVEC_FIFO_CHGONLY_EN
  logic [WIDTH-1:0] last_q, last_d;
  logic             first_q, first_d;

  assign is_new = first_q || (in_data != last_q);

  // Only accepted samples update the reference; a full-FIFO drop leaves it untouched.
  always_comb begin
    last_d  = last_q;
    first_d = first_q;
    if (push) begin
      last_d  = in_data;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= '0;
      first_q <= 1'b1;
    end else begin
      last_q  <= last_d;
      first_q <= first_d;
    end
  end
`else
  assign is_new = 1'b1;
`endif

  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign offered   = in_valid && is_new;
  assign push      = offered && (!full || pop);
  assign drop      = offered && full && !pop;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  v_hier_qvec_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign out_data = out_valid ? rdata : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_v_hier_qvec_fifo.sv
// Scoreboard bench for v_hier_qvec_fifo: stimulus queues expected samples, a negedge monitor checks pops.
module tb_v_hier_qvec_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       count;
  logic             overflow;
  logic             clr_ovf;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q [$];

  v_hier_qvec_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake seen before the edge must match the oldest expected sample.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {28'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("pop_data", {28'd0, out_data}, {28'd0, e});
        $display("pop data=%0h expected=%0h", out_data, e);
      end
    end
  end

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    do_reset();
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {28'd0, out_data}, 32'd0);

    // Two pushes, no consumer: head is the first sample from the next cycle on.
    in_valid = 1'b1; in_data = 4'h3; exp_q.push_back(4'h3);
    tick();
    $display("push data=3");
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {28'd0, out_data}, 32'h3);
    in_data = 4'h5; exp_q.push_back(4'h5);
    tick();
    $display("push data=5");
    in_valid = 1'b0;
    chk("two_count", {28'd0, count}, 32'd2);
    chk("two_head", {28'd0, out_data}, 32'h3);
    drain(2);
    chk("two_empty", {28'd0, count}, 32'd0);
    chk("empty_data", {28'd0, out_data}, 32'd0);

    // Fill 0..7 then offer A while full: dropped.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i); exp_q.push_back(WIDTH'(i));
      tick();
      $display("push data=%0h", i);
    end
    chk("full_count", {28'd0, count}, 32'd8);
    in_data = 4'hA;
    tick();
    $display("push data=a (drop)");
    chk("drop_count", {28'd0, count}, 32'd8);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);

    // Drop and clear in the same cycle: set wins.
    in_data = 4'hC; clr_ovf = 1'b1;
    tick();
    $display("push data=c (drop with clear)");
    chk("setwins_ovf", {31'd0, overflow}, 32'd1);
    in_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    chk("clear_ovf", {31'd0, overflow}, 32'd0);
    chk("clear_count", {28'd0, count}, 32'd8);

    // Full with simultaneous pop and push: push accepted.
    in_valid = 1'b1; in_data = 4'hB; out_ready = 1'b1; exp_q.push_back(4'hB);
    tick();
    $display("push data=b (full, with pop)");
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullpp_count", {28'd0, count}, 32'd8);
    chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
    drain(8);
    chk("drain_count", {28'd0, count}, 32'd0);

    // Wrap: 20 interleaved push/pop cycles.
    for (int i = 0; i < 20; i++) begin
      d = WIDTH'(i * 3 + 1);
      in_valid = 1'b1; in_data = d; out_ready = 1'b1; exp_q.push_back(d);
      tick();
      $display("push data=%0h", d);
      chk("wrap_count_le1", {31'd0, (count <= 4'd1)}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("wrap_count", {28'd0, count}, 32'd0);

`ifdef V_HIER_QVEC_FIFO_CHGONLY_EN
    do_reset();
    begin
      logic [WIDTH-1:0] seq [5];
      seq = '{4'h2, 4'h2, 4'h7, 4'h7, 4'h2};
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1; in_data = seq[i];
        tick();
        $display("push data=%0h", seq[i]);
      end
    end
    in_valid = 1'b0;
    exp_q.push_back(4'h2); exp_q.push_back(4'h7); exp_q.push_back(4'h2);
    chk("chg_count", {28'd0, count}, 32'd3);
    chk("chg_ovf", {31'd0, overflow}, 32'd0);
    drain(3);
    chk("chg_empty", {28'd0, count}, 32'd0);
`endif

    chk("scoreboard_left", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/v_hier_qvec_fifo.md
# v_hier_qvec_fifo

Downstream buffer for the `qvec` vector produced by `v_hier_sub` inside the hierarchy top. It captures qualified `qvec` samples into a small synchronous FIFO and presents them to a consumer over a valid/ready handshake. It tracks occupancy and flags dropped samples with a sticky overflow bit.

## Interface
Parameters:
- `WIDTH`, default 4: sample width; matches the `qvec` width.
- `DEPTH`, default 8: number of entries; power of two, at least 2.

Ports:
- `clk`, input, 1: sole clock; all logic on its rising edge.
- `rst`, input, 1: reset is synchronous and active-high.
- `in_valid`, input, 1: a `qvec` sample is offered this cycle.
- `in_data`, input, WIDTH: the `qvec` sample.
- `out_valid`, output, 1: head entry available.
- `out_ready`, input, 1: consumer accepts the head this cycle.
- `out_data`, output, WIDTH: head entry.
- `count`, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky flag; a sample was dropped.
- `clr_ovf`, input, 1: clears `overflow`.

## Operation
- Pop: `out_valid && out_ready`. Advances the read pointer and decrements `count`.
- Push: `in_valid && (count < DEPTH || pop)`. Writes `in_data` at the write pointer, advances the write pointer, and increments `count`.
- Simultaneous push and pop: both happen and `count` is unchanged. This includes the full case, where the push is accepted.
- Empty with push: there is no bypass. The sample appears at `out_data` on the next cycle.
- Drop: `in_valid` while full with no pop. The sample is discarded, `overflow` is set, and the pointers are unchanged.
- `clr_ovf` clears `overflow` on the next edge. If a drop happens in the same cycle as `clr_ovf`, set wins and `overflow` stays 1.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case. Full and empty are derived from `count` only.
- `out_valid` = (`count` != 0).
- `out_data` = storage at the read pointer when `out_valid` is 1, and forced to 0 when empty.
- `out_ready` while empty has no effect.

## Timing
- Reset values: `count`=0, `overflow`=0, `out_valid`=0, `out_data`=0, and both pointers 0. Storage contents are not reset.
- Reset mid-operation: the contents are discarded. Any push or pop in the reset cycle is ignored.
- Latency: a push at edge N is visible on `out_valid`/`out_data` after edge N, so it can be consumed in cycle N+1.
- `count`, `overflow` and `out_valid` are registered or derived from registers only. There is no combinational path from `in_*` to `out_*`.
- The only combinational path is `out_ready` to internal pop. `out_valid` does not depend on `out_ready`.
- Maximum throughput is one push and one pop per cycle.

## Configuration
- Macro: `V_HIER_QVEC_FIFO_CHGONLY_EN`.
- Defined: a push additionally requires `in_data` to differ from the last accepted sample.
  - The last accepted sample is held in a register with a "first" flag. After reset, the first valid sample is always pushed.
  - A suppressed repeat is not a drop and never sets `overflow`.
  - A drop when full does not update the last-accepted register.
- Undefined: every qualified `in_valid` is pushed. The last-accepted register and "first" flag are not built.

## Structure
- Package `v_hier_pkg` holds:
  - `QVEC_W` = 4, which is the default for `WIDTH`.
  - typedef `qvec_t` (logic [QVEC_W-1:0]).
  - function `ptr_w(depth)` returning $clog2(depth).
- One sub-module, `v_hier_qvec_mem`: a DEPTH x WIDTH register array with one write port and one asynchronous read port.
- Pointer, count, overflow and change-detect logic stay in `v_hier_qvec_fifo`.

## Test plan
- Reset then idle: all outputs 0. Push 4'h3, 4'h5 on consecutive cycles with `out_ready`=0. Required: `count`=2, `out_data`=4'h3, `out_valid`=1 from the cycle after the first push.
- Fill DEPTH=8 with 0..7, then offer 4'hA with `out_ready`=0. Required: `count` stays 8, `overflow`=1, and the drain order is 0..7 with no A.
- Full with `out_ready`=1 and `in_valid`=1 (4'hB) in the same cycle. Required: `count` stays 8, `overflow` stays 0, and B is read last.
- Sticky set/clear: raise `clr_ovf` in the same cycle as a drop. Required: `overflow` stays 1. Raise `clr_ovf` alone next. Required: `overflow`=0 on the following cycle.
- Wrap: run 20 pushes and pops interleaved one-for-one. Required: the output sequence equals the input sequence and `count` never exceeds 1.
- With `V_HIER_QVEC_FIFO_CHGONLY_EN` defined, push 4'h2, 4'h2, 4'h7, 4'h7, 4'h2. Required: the FIFO holds 2, 7, 2, `count`=3, `overflow`=0.
